// File: rtl/adder_tree_accumulator.sv
// rtl/adder_tree_accumulator.sv - accumulates adder tree sums into wide results behind a 2-entry output FIFO
module adder_tree_accumulator #(
  parameter int IN_WIDTH  = 10,
  parameter int ACC_LEN   = 8,
  parameter int CNT_W     = $clog2(ACC_LEN + 1),
  parameter int OUT_WIDTH = IN_WIDTH + $clog2(ACC_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [IN_WIDTH-1:0]  i_sum,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OUT_WIDTH-1:0] o_result,
  output logic [CNT_W-1:0]     o_count,
  output logic                 o_overflow,
  output logic                 o_busy
);

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(ACC_LEN);

  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;
  logic [1:0]           occ_q, occ_d;
  logic [OUT_WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
  logic [CNT_W-1:0]     cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic [OUT_WIDTH-1:0] sum_inc;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 complete;
  logic                 pop;

  // Accumulator: fold in the current sample, close the result on length or flush
  always_comb begin
    sum_inc = acc_q;
    cnt_inc = cnt_q;
    if (i_valid) begin
      sum_inc = (cnt_q == '0) ? OUT_WIDTH'(i_sum) : acc_q + OUT_WIDTH'(i_sum);
      cnt_inc = cnt_q + CNT_W'(1);
    end
    complete = (i_valid && (cnt_inc == LEN_C)) || (i_flush && (cnt_inc != '0));
    acc_d    = complete ? '0 : sum_inc;
    cnt_d    = complete ? '0 : cnt_inc;
    busy_d   = (cnt_d != '0);
  end

  // Output FIFO: entry 0 is the head; a push into a full FIFO without a pop is dropped
  always_comb begin
    pop    = (occ_q != 2'd0) && i_ready;
    occ_d  = occ_q;
    res0_d = res0_q;
    res1_d = res1_q;
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    ovf_d  = ovf_q;
    case ({complete, pop})
      2'b01: begin
        res0_d = res1_q;
        cnt0_d = cnt1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          res0_d = sum_inc;
          cnt0_d = cnt_inc;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          res1_d = sum_inc;
          cnt1_d = cnt_inc;
          occ_d  = 2'd2;
        end else begin
          ovf_d = 1'b1;
        end
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          res0_d = sum_inc;
          cnt0_d = cnt_inc;
        end else begin
          res0_d = res1_q;
          cnt0_d = cnt1_q;
          res1_d = sum_inc;
          cnt1_d = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      occ_q  <= 2'd0;
      res0_q <= '0;
      res1_q <= '0;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
      occ_q  <= occ_d;
      res0_q <= res0_d;
      res1_q <= res1_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign o_valid    = (occ_q != 2'd0);
  assign o_result   = res0_q;
  assign o_count    = cnt0_q;
  assign o_overflow = ovf_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// tb/tb_adder_tree_accumulator.sv - self-checking bench for adder_tree_accumulator
module tb_adder_tree_accumulator;

  localparam int IN_WIDTH  = 10;
  localparam int ACC_LEN   = 8;
  localparam int CNT_W     = $clog2(ACC_LEN + 1);
  localparam int OUT_WIDTH = IN_WIDTH + $clog2(ACC_LEN);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 i_valid = 1'b0;
  logic [IN_WIDTH-1:0]  i_sum = '0;
  logic                 i_flush = 1'b0;
  logic                 i_ready = 1'b1;
  logic                 o_valid;
  logic [OUT_WIDTH-1:0] o_result;
  logic [CNT_W-1:0]     o_count;
  logic                 o_overflow;
  logic                 o_busy;

  adder_tree_accumulator #(
    .IN_WIDTH (IN_WIDTH),
    .ACC_LEN  (ACC_LEN),
    .CNT_W    (CNT_W),
    .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_sum     (i_sum),
    .i_flush   (i_flush),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_result  (o_result),
    .o_count   (o_count),
    .o_overflow(o_overflow),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int cnt;
  } item_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: running sum, sample count, list of pending results
  int    m_acc = 0;
  int    m_cnt = 0;
  item_t m_q[$];
  bit    m_ovf = 1'b0;
  bit    m_started = 1'b0;

  always @(posedge clk) begin
    int  ncnt;
    int  nsum;
    bit  comp;
    bit  popped;
    item_t it;
    if (rst) begin
      m_acc = 0;
      m_cnt = 0;
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      popped = (m_q.size() > 0) && i_ready;
      ncnt   = m_cnt + (i_valid ? 1 : 0);
      nsum   = i_valid ? (m_cnt == 0 ? int'(i_sum) : m_acc + int'(i_sum)) : m_acc;
      comp   = (i_valid && ncnt == ACC_LEN) || (i_flush && ncnt > 0);
      if (popped) void'(m_q.pop_front());
      if (comp) begin
        if (m_q.size() < 2) begin
          it.res = nsum;
          it.cnt = ncnt;
          m_q.push_back(it);
        end else begin
          m_ovf = 1'b1;
        end
        m_acc = 0;
        m_cnt = 0;
      end else begin
        m_acc = nsum;
        m_cnt = ncnt;
      end
    end
    m_started = 1'b1;
  end

  // Results actually delivered by the DUT, in order
  item_t dut_log[$];

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    item_t it;
    if (m_started) begin
      chk("o_valid", 32'(o_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("o_result", 32'(o_result), 32'(m_q[0].res));
        chk("o_count", 32'(o_count), 32'(m_q[0].cnt));
      end
      chk("o_overflow", 32'(o_overflow), 32'(m_ovf));
      chk("o_busy", 32'(o_busy), 32'(m_cnt != 0));
      if (o_valid && i_ready && !rst) begin
        it.res = int'(o_result);
        it.cnt = int'(o_count);
        dut_log.push_back(it);
      end
    end
  end

  task automatic cyc(input bit v, input int s, input bit f);
    logic [31:0] sv;
    @(posedge clk);
    #1;
    sv      = s;
    i_valid = v;
    i_sum   = sv[IN_WIDTH-1:0];
    i_flush = f;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_log(input string name, input int idx, input int res, input int cnt);
    if (idx < dut_log.size()) begin
      chk({name, "_res"}, 32'(dut_log[idx].res), 32'(res));
      chk({name, "_cnt"}, 32'(dut_log[idx].cnt), 32'(cnt));
    end else begin
      chk({name, "_present"}, 32'(dut_log.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_result", 32'(o_result), 32'd0);
    chk("rst_o_count", 32'(o_count), 32'd0);
    chk("rst_o_overflow", 32'(o_overflow), 32'd0);
    chk("rst_o_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;

    // Eight back-to-back samples 1..8
    dut_log.delete();
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, k, 1'b0);
      if (k == 2) chk("seq_busy_after_s1", 32'(o_busy), 32'd1);
    end
    cyc(1'b0, 0, 1'b0);
    chk("seq_o_valid", 32'(o_valid), 32'd1);
    chk("seq_o_result", 32'(o_result), 32'd36);
    chk("seq_o_count", 32'(o_count), 32'd8);
    chk("seq_busy_done", 32'(o_busy), 32'd0);
    cyc(1'b0, 0, 1'b0);
    chk("seq_o_valid_after_pop", 32'(o_valid), 32'd0);
    chk("seq_log_size", 32'(dut_log.size()), 32'd1);

    // Same samples with bubbles
    dut_log.delete();
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, k, 1'b0);
      cyc(1'b0, 0, 1'b0);
      if (k < 8) chk("bub_busy", 32'(o_busy), 32'd1);
    end
    idle(3);
    chk("bub_log_size", 32'(dut_log.size()), 32'd1);
    chk_log("bub", 0, 36, 8);

    // Early flush of a partial accumulation, then a no-op flush
    dut_log.delete();
    for (int k = 0; k < 3; k++) cyc(1'b1, 1023, 1'b0);
    cyc(1'b0, 0, 1'b1);
    idle(3);
    cyc(1'b0, 0, 1'b1);
    idle(3);
    chk("flush_log_size", 32'(dut_log.size()), 32'd1);
    chk_log("flush", 0, 3069, 3);

    // Stall: three full-scale results, third dropped
    dut_log.delete();
    i_ready = 1'b0;
    for (int k = 0; k < 24; k++) cyc(1'b1, 1023, 1'b0);
    cyc(1'b0, 0, 1'b0);
    chk("stall_o_overflow", 32'(o_overflow), 32'd1);
    chk("stall_o_result", 32'(o_result), 32'd8184);
    i_ready = 1'b1;
    idle(5);
    chk("stall_log_size", 32'(dut_log.size()), 32'd2);
    chk_log("stall0", 0, 8184, 8);
    chk_log("stall1", 1, 8184, 8);
    chk("stall_ovf_sticky", 32'(o_overflow), 32'd1);

    // Full FIFO with a completion in the same cycle as a pop
    do_reset();
    dut_log.delete();
    i_ready = 1'b0;
    for (int k = 0; k < 8; k++) cyc(1'b1, 1, 1'b0);
    for (int k = 0; k < 8; k++) cyc(1'b1, 2, 1'b0);
    for (int k = 0; k < 7; k++) cyc(1'b1, 3, 1'b0);
    cyc(1'b1, 3, 1'b0);
    i_ready = 1'b1;
    idle(5);
    chk("pushpop_ovf", 32'(o_overflow), 32'd0);
    chk("pushpop_log_size", 32'(dut_log.size()), 32'd3);
    chk_log("pushpop0", 0, 8, 8);
    chk_log("pushpop1", 1, 16, 8);
    chk_log("pushpop2", 2, 24, 8);

    // Reset mid-accumulation discards the partial sum
    dut_log.delete();
    for (int k = 0; k < 5; k++) cyc(1'b1, 100, 1'b0);
    do_reset();
    dut_log.delete();
    for (int k = 0; k < 8; k++) cyc(1'b1, 2, 1'b0);
    idle(3);
    chk("rstmid_log_size", 32'(dut_log.size()), 32'd1);
    chk_log("rstmid", 0, 16, 8);

    // Randomized traffic against the model
    for (int seg = 0; seg < 6; seg++) begin
      int rdy_pct;
      rdy_pct = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 60 : 95);
      for (int k = 0; k < 500; k++) begin
        @(posedge clk);
        #1;
        rst     = ($urandom_range(0, 299) == 0);
        i_valid = ($urandom_range(0, 3) != 0);
        i_sum   = ($urandom_range(0, 3) == 0) ? 10'd1023 : 10'($urandom_range(0, 1023));
        i_flush = ($urandom_range(0, 15) == 0);
        i_ready = ($urandom_range(0, 99) < rdy_pct);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_valid = 1'b0;
    i_flush = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_tree_accumulator.md
Name: adder_tree_accumulator

Overview:
- Sits directly downstream of the adder tree; consumes its per-cycle reduced sum and o_valid strobe.
- Accumulates ACC_LEN consecutive valid sums (e.g. partial dot-product chunks) into one wide result.
- Presents results on a valid/ready output through a 2-entry output FIFO, since the adder tree has no backpressure.
- Supports early flush of a partial accumulation and flags dropped results.

Parameters:
- IN_WIDTH, 10, width of incoming unsigned sum (adder tree default: DATAWIDTH=4, NUM_INPUTS=16).
- ACC_LEN, 8, number of valid input sums per result; legal range 1..256.
- CNT_W, $clog2(ACC_LEN+1), width of the sample counter and o_count.
- OUT_WIDTH, IN_WIDTH+$clog2(ACC_LEN), result width; must never overflow for ACC_LEN full-scale inputs.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  input sum valid (driven by adder tree o_valid); no ready, always accepted.
- i_sum  input  IN_WIDTH  unsigned sum from adder tree sum_reg.
- i_flush  input  1  close the current accumulation early.
- o_valid  output  1  FIFO head valid.
- i_ready  input  1  downstream accepts head when o_valid && i_ready.
- o_result  output  OUT_WIDTH  accumulated result at FIFO head.
- o_count  output  CNT_W  number of samples contained in o_result (1..ACC_LEN).
- o_overflow  output  1  sticky: a completed result was dropped because the FIFO was full.
- o_busy  output  1  high while a partial accumulation is held (cnt != 0).

Behaviour:
- One clock; reset is synchronous and active-high (clock port clk, reset port rst).
- Reset: acc=0, cnt=0, FIFO empty; o_valid=0, o_result=0, o_count=0, o_overflow=0, o_busy=0. Reset mid-accumulation discards the partial sum; FIFO contents are lost.
- Accumulate path, per cycle with i_valid=1:
  - next = (cnt==0) ? i_sum : acc + i_sum, zero-extended to OUT_WIDTH.
  - cnt_next = cnt+1.
- Completion: occurs when cnt_next==ACC_LEN, or when i_flush=1 and cnt_next>0.
  - On completion, push {next, cnt_next} into the FIFO; reset acc=0 and cnt=0.
- Flush cases:
  - i_flush with i_valid in the same cycle: the current sample is included.
  - i_flush with cnt==0 and i_valid=0: no-op, nothing is pushed.
- Latency: the result appears at the FIFO head (o_valid=1) the cycle after the completing sample, if the FIFO was empty.
- States: IDLE (cnt==0), ACCUM (0<cnt<ACC_LEN). Full never persists because completion resets cnt. ACC_LEN=1 makes every valid sample a completion.
- FIFO: depth 2, first-word-fall-through; outputs are registered from FIFO storage.
  - Pop when o_valid && i_ready.
  - Push and pop in the same cycle are legal at any occupancy, including full.
  - o_result and o_count hold stable while o_valid && !i_ready.
- Overflow: if a push occurs while the FIFO is full and no pop occurs that cycle:
  - the new result is dropped and the FIFO is unchanged;
  - o_overflow is set and stays 1 until rst;
  - the accumulator still resets to begin the next accumulation.
- i_valid=0 cycles (bubbles) leave acc and cnt unchanged.
- o_busy = (cnt != 0), registered.

Test Plan:
- Reset then 8 consecutive i_valid with i_sum=1..8, i_ready=1 -> one cycle after the 8th sample: o_valid=1, o_result=36, o_count=8; then o_valid=0.
- Same 8 samples with i_valid bubbles interleaved (valid every other cycle) -> o_result=36, o_count=8; o_busy=1 from sample 1 through sample 8.
- 3 samples (1023,1023,1023), then i_flush alone -> o_result=3069, o_count=3. A further i_flush with cnt==0 -> no output.
- i_ready=0, three full accumulations of 8×1023 -> two entries of 8184 held in the FIFO; third result dropped with o_overflow=1. Then raise i_ready -> exactly two pops, o_overflow remains 1.
- FIFO full with a completion in the same cycle as a pop -> no drop, o_overflow=0, results are delivered in order.
- Assert rst after 5 samples, then 8 samples of 2 -> o_result=16, o_count=8; the pre-reset partial sum is absent.
